// File: rtl/sq_pkg.sv
// rtl/sq_pkg.sv - shared FSM state type and counter sizing for the sequential squarer
package sq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } sq_state_t;

  // Counter must hold values 0..width, hence width+1 codes.
  function automatic int sq_cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sq_shift_add_dp.sv
// rtl/sq_shift_add_dp.sv - shift-add datapath: magnitude load, accumulator, shift registers
module sq_shift_add_dp
  import sq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   operand,
  input  logic               op_signed,
  output logic [2*WIDTH-1:0] result
);

  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [WIDTH-1:0]   mag;

  // Negating the most negative value wraps to itself, which is the correct unsigned magnitude.
  always_comb begin
    mag = operand;
    if (op_signed && operand[WIDTH-1]) begin
      mag = ~operand + WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, mag};
      mplier <= mag;
    end else if (step) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign result = acc;

endmodule

// File: rtl/seq_squarer.sv
// rtl/seq_squarer.sv - iterative squarer top: handshake FSM, iteration counter, datapath instance
module seq_squarer
  import sq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_data,
  output logic               busy
);

  localparam int CW = sq_cnt_width(WIDTH);

  sq_state_t     state;
  sq_state_t     state_nxt;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          last_iter;

  assign accept    = in_valid && in_ready;
  assign last_iter = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // DONE with out_ready and in_valid hands off straight into CALC, so streams run without bubbles.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy     = 1'b0;
        in_ready = 1'b1;
        if (in_valid) begin
          state_nxt = CALC;
        end
      end
      CALC: begin
        if (last_iter) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) begin
          state_nxt = in_valid ? CALC : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= '0;
    end else if (state == CALC) begin
      cnt <= cnt + CW'(1);
    end
  end

  sq_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state == CALC),
    .operand  (in_data),
    .op_signed(in_signed),
    .result   (out_data)
  );

endmodule

// File: tb/tb_seq_squarer.sv
// tb/tb_seq_squarer.sv - directed bench for seq_squarer at WIDTH 3, 8 and 32
module tb_seq_squarer;

  logic clk;
  logic rst_n;

  logic        in_valid3, in_ready3, in_signed3, out_valid3, out_ready3, busy3;
  logic [2:0]  in_data3;
  logic [5:0]  out_data3;

  logic        in_valid8, in_ready8, in_signed8, out_valid8, out_ready8, busy8;
  logic [7:0]  in_data8;
  logic [15:0] out_data8;

  logic        in_valid32, in_ready32, in_signed32, out_valid32, out_ready32, busy32;
  logic [31:0] in_data32;
  logic [63:0] out_data32;

  int checks = 0;
  int errors = 0;

  seq_squarer #(.WIDTH(3)) u_sq3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid3), .in_ready(in_ready3),
    .in_data(in_data3), .in_signed(in_signed3), .out_valid(out_valid3),
    .out_ready(out_ready3), .out_data(out_data3), .busy(busy3)
  );

  seq_squarer #(.WIDTH(8)) u_sq8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .in_data(in_data8), .in_signed(in_signed8), .out_valid(out_valid8),
    .out_ready(out_ready8), .out_data(out_data8), .busy(busy8)
  );

  seq_squarer #(.WIDTH(32)) u_sq32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid32), .in_ready(in_ready32),
    .in_data(in_data32), .in_signed(in_signed32), .out_valid(out_valid32),
    .out_ready(out_ready32), .out_data(out_data32), .busy(busy32)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] sq_ref(input logic [31:0] d, input logic s);
    logic [31:0] m;
    m = (s && d[31]) ? (32'd0 - d) : d;
    return {32'd0, m} * {32'd0, m};
  endfunction

  // Entered at a negedge with the WIDTH=8 instance idle; leaves it idle at a negedge.
  task automatic run8(input logic [7:0] d, input logic s, input logic [15:0] exp, input string tag);
    in_data8   = d;
    in_signed8 = s;
    in_valid8  = 1'b1;
    out_ready8 = 1'b1;
    #1;
    check({tag, "_in_ready_idle"}, 64'(in_ready8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    check({tag, "_busy_calc"}, 64'(busy8), 64'd1);
    check({tag, "_in_ready_calc"}, 64'(in_ready8), 64'd0);
    repeat (7) @(negedge clk);
    check({tag, "_no_early_valid"}, 64'(out_valid8), 64'd0);
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid8), 64'd1);
    check({tag, "_out_data"}, 64'(out_data8), 64'(exp));
    @(negedge clk);
    check({tag, "_back_idle_valid"}, 64'(out_valid8), 64'd0);
    check({tag, "_back_idle_busy"}, 64'(busy8), 64'd0);
  endtask

  logic [5:0]  exp3 [8];
  logic [31:0] dir32 [3];
  logic        dsg32 [3];
  logic [63:0] exp_q [$];
  logic [63:0] exp_pop;
  int          sent;
  int          got;
  logic        took;
  localparam int N32 = 25;

  initial begin
    exp3  = '{6'd0, 6'd1, 6'd4, 6'd9, 6'd16, 6'd25, 6'd36, 6'd49};
    dir32 = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    dsg32 = '{1'b1, 1'b0, 1'b1};

    rst_n = 1'b0;
    in_valid3 = 1'b0;  in_data3 = '0;  in_signed3 = 1'b0;  out_ready3 = 1'b0;
    in_valid8 = 1'b0;  in_data8 = '0;  in_signed8 = 1'b0;  out_ready8 = 1'b0;
    in_valid32 = 1'b0; in_data32 = '0; in_signed32 = 1'b0; out_ready32 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    check("rst_in_ready8", 64'(in_ready8), 64'd1);
    check("rst_out_valid8", 64'(out_valid8), 64'd0);
    check("rst_out_data8", 64'(out_data8), 64'd0);
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_out_data3", 64'(out_data3), 64'd0);
    check("rst_out_data32", out_data32, 64'd0);

    // First accept on the very first rising edge after release.
    rst_n = 1'b1;
    run8(8'hFF, 1'b0, 16'd65025, "w8_u_ff");

    // WIDTH=3 back-to-back stream with no idle cycle between operands.
    out_ready3 = 1'b1;
    in_signed3 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      in_data3  = 3'(i);
      in_valid3 = 1'b1;
      #1;
      check("w3_in_ready", 64'(in_ready3), 64'd1);
      @(posedge clk);
      @(negedge clk);
      in_valid3 = 1'b0;
      check("w3_calc_valid", 64'(out_valid3), 64'd0);
      repeat (2) begin
        @(negedge clk);
        check("w3_calc_valid", 64'(out_valid3), 64'd0);
      end
      @(negedge clk);
      check("w3_out_valid", 64'(out_valid3), 64'd1);
      check("w3_out_data", 64'(out_data3), 64'(exp3[i]));
    end
    @(negedge clk);
    check("w3_end_valid", 64'(out_valid3), 64'd0);
    check("w3_end_busy", 64'(busy3), 64'd0);

    run8(8'hFF, 1'b1, 16'd1, "w8_s_ff");
    run8(8'h80, 1'b1, 16'd16384, "w8_s_80");
    run8(8'h80, 1'b0, 16'd16384, "w8_u_80");
    run8(8'h00, 1'b0, 16'd0, "w8_zero");
    run8(8'h7F, 1'b1, 16'd16129, "w8_s_7f");

    // Back-pressure: result held 20 cycles, a stray in_valid pulse must not be taken.
    out_ready8 = 1'b0;
    in_data8   = 8'hC8;
    in_signed8 = 1'b0;
    in_valid8  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (7) @(negedge clk);
    check("stall_pre_valid", 64'(out_valid8), 64'd0);
    @(negedge clk);
    for (int k = 0; k < 20; k++) begin
      if (k == 10) begin
        in_valid8 = 1'b1;
        in_data8  = 8'h03;
      end else begin
        in_valid8 = 1'b0;
      end
      #1;
      check("stall_out_valid", 64'(out_valid8), 64'd1);
      check("stall_out_data", 64'(out_data8), 64'd40000);
      check("stall_in_ready", 64'(in_ready8), 64'd0);
      @(negedge clk);
    end
    in_valid8  = 1'b0;
    out_ready8 = 1'b1;
    @(negedge clk);
    check("stall_release_valid", 64'(out_valid8), 64'd0);
    check("stall_pulse_dropped", 64'(busy8), 64'd0);

    // Reset in the 4th CALC cycle aborts the operation.
    in_data8   = 8'h55;
    in_signed8 = 1'b0;
    in_valid8  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid8 = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_busy_before", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(out_valid8), 64'd0);
    check("abort_out_data", 64'(out_data8), 64'd0);
    check("abort_busy", 64'(busy8), 64'd0);
    check("abort_in_ready", 64'(in_ready8), 64'd1);
    @(posedge clk);
    @(negedge clk);
    check("abort_held_valid", 64'(out_valid8), 64'd0);
    rst_n = 1'b1;
    run8(8'd12, 1'b0, 16'd144, "w8_after_abort");

    // WIDTH=32 stream with random operands and random out_ready against a reference queue.
    sent = 0;
    got  = 0;
    took = 1'b0;
    for (int cyc = 0; cyc < 20000 && got < N32; cyc++) begin
      if (took) in_valid32 = 1'b0;
      took = 1'b0;
      if (!in_valid32 && sent < N32 && ($urandom_range(0, 1) == 1)) begin
        if (sent < 3) begin
          in_data32   = dir32[sent];
          in_signed32 = dsg32[sent];
        end else begin
          in_data32   = $urandom;
          in_signed32 = 1'($urandom_range(0, 1));
        end
        in_valid32 = 1'b1;
      end
      out_ready32 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid32 && out_ready32) begin
        check("w32_result_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          exp_pop = exp_q.pop_front();
          check("w32_out_data", out_data32, exp_pop);
        end
        got++;
      end
      if (in_valid32 && in_ready32) begin
        exp_q.push_back(sq_ref(in_data32, in_signed32));
        sent++;
        took = 1'b1;
      end
      @(negedge clk);
    end
    in_valid32  = 1'b0;
    out_ready32 = 1'b0;
    check("w32_result_count", 64'(got), 64'(N32));
    check("w32_queue_drained", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seq_squarer.md
SEQ_SQUARER -- requirements
Module: seq_squarer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width in bits; legal range 2..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  operand present this cycle.
REQ-005 SHALL have port in_ready  output  1  block can accept an operand this cycle.
REQ-006 SHALL have port in_data  input  WIDTH  operand.
REQ-007 SHALL have port in_signed  input  1  operand is two's complement (1) or unsigned (0); sampled with in_data.
REQ-008 SHALL have port out_valid  output  1  result present.
REQ-009 SHALL have port out_ready  input  1  consumer takes the result this cycle.
REQ-010 SHALL have port out_data  output  2*WIDTH  square of the accepted operand.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have one clock, clk; reset SHALL be rst_n, asynchronous and active-low.

Function
REQ-013 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-014 SHALL assert in_ready in IDLE and, in DONE, only while out_ready=1; otherwise in_ready SHALL be 0.
REQ-015 Accept SHALL occur on a rising edge with in_valid=1 and in_ready=1; the FSM SHALL then move to CALC.
REQ-016 On accept with in_signed=1 and in_data[WIDTH-1]=1, the block SHALL compute the square of the two's-complement magnitude; otherwise it SHALL use in_data unsigned.
REQ-017 CALC SHALL perform one shift-add iteration per cycle: if the multiplier LSB is 1, add the multiplicand to the accumulator; then shift the multiplicand left and the multiplier right.
REQ-018 CALC SHALL last exactly WIDTH cycles, counted by an iteration counter cleared on accept.
REQ-019 On the edge completing iteration WIDTH, the FSM SHALL move to DONE and assert out_valid; latency from accept edge to out_valid high SHALL be WIDTH cycles.
REQ-020 out_data SHALL be exact with no truncation for all inputs; magnitude 2^(WIDTH-1) SHALL give 2^(2*WIDTH-2).
REQ-021 out_data and out_valid SHALL remain stable in DONE until out_ready=1.
REQ-022 In DONE with out_ready=1 and in_valid=0, the FSM SHALL return to IDLE and deassert out_valid.
REQ-023 In DONE with out_ready=1 and in_valid=1, the result SHALL be consumed and the new operand accepted on the same edge, going directly to CALC; no idle bubble is allowed.
REQ-024 in_valid during CALC SHALL be ignored (in_ready=0); the operand SHALL NOT be lost if the source holds it.
REQ-025 out_ready outside DONE SHALL have no effect.
REQ-026 The accumulator SHALL be cleared on every accept; no residue from a prior operation is allowed.

Reset
REQ-027 rst_n=0 SHALL immediately force state=IDLE, out_valid=0, out_data=0, busy=0, counter=0, and accumulator=0; in_ready SHALL be 1 after reset.
REQ-028 Reset during CALC or DONE SHALL abort the operation, and no result for it SHALL ever appear.
REQ-029 The first accept after reset release SHALL be permitted on the first rising edge with rst_n=1.

Structure
REQ-030 A shared package sq_pkg SHALL hold the FSM state enum (IDLE, CALC, DONE) and a constant function returning the counter width, clog2(WIDTH+1).
REQ-031 The datapath (accumulator, shift registers, adder) SHALL be one sub-module, sq_shift_add_dp; the FSM, handshake and counter SHALL stay in seq_squarer.
REQ-032 The design SHALL not use the * operator; the square SHALL come only from the iterative shift-add datapath.

Verification
REQ-033 WIDTH=3, all 8 unsigned operands back-to-back with out_ready=1 -> 0,1,4,9,16,25,36,49, each WIDTH=3 cycles after accept, with no bubbles.
REQ-034 WIDTH=8: unsigned 0xFF -> 65025; signed 0xFF -> 1; signed 0x80 -> 16384; unsigned 0x80 -> 16384; 0x00 -> 0.
REQ-035 WIDTH=8 with out_ready held 0 for 20 cycles after out_valid -> out_data stable, in_ready=0, and an in_valid pulse meanwhile is not accepted.
REQ-036 WIDTH=8: rst_n pulsed low at the 4th CALC cycle -> outputs immediately at reset values; the next operand 12 yields 144 with no corruption.
REQ-037 WIDTH=32: random mixed signed/unsigned operands with random out_ready -> every result matches the reference model, in order, with none dropped or duplicated.
